// File: rtl/rf_exec_ctrl.sv
// rf_exec_ctrl: multi-cycle execute/write-back sequencer placed upstream of the
// register file. It takes one instruction per handshake and steps through
// IDLE -> READ -> EXEC -> WB. It drives the read addresses, captures the
// operands, computes the ALU result and issues a single write-back cycle
// with a done pulse.
// Optional build macro RF_EXEC_FLAGS_EN adds the registered flag_z/flag_c outputs.
module rf_exec_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic [DW-1:0] instr_imm,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic          we,
  output logic          done
`ifdef RF_EXEC_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_c
`endif
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL1 = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t        state_q, state_d;

  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic [AW-1:0] ra1_q, ra2_q;
  logic [DW-1:0] a_q, b_q;
  logic [AW-1:0] wa_q;
  logic [DW-1:0] wd_q, wd_d;
  logic          we_q, done_q;

  logic          accept;
  logic          ld_operands;
  logic          ld_result;

  // ALU result, wrapping modulo 2**DW; NOP produces zero (never written).
  function automatic logic [DW-1:0] alu_res(input logic [2:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [DW-1:0] imm);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL1: r = {a[DW-2:0], 1'b0};
      OP_LDI:  r = imm;
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef RF_EXEC_FLAGS_EN
  // Carry for ADD, borrow for SUB, shifted-out MSB for SHL1, otherwise 0.
  function automatic logic alu_carry(input logic [2:0] op,
                                     input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
    logic [DW:0] sum;
    logic        c;
    sum = {1'b0, a} + {1'b0, b};
    c   = 1'b0;
    case (op)
      OP_ADD:  c = sum[DW];
      OP_SUB:  c = (a < b);
      OP_SHL1: c = a[DW-1];
      default: c = 1'b0;
    endcase
    return c;
  endfunction
`endif

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: fixed four-step walk, leaving IDLE only on a handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/strobe decode from the registered state.
  always_comb begin
    instr_ready = (state_q == S_IDLE);
    accept      = instr_valid && (state_q == S_IDLE);
    ld_operands = (state_q == S_READ);
    ld_result   = (state_q == S_EXEC);
    wd_d        = alu_res(op_q, a_q, b_q, imm_q);
  end

  // Stage 0: latch the instruction; read addresses go live for READ.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      op_q  <= '0;
      rd_q  <= '0;
      imm_q <= '0;
      ra1_q <= '0;
      ra2_q <= '0;
    end else if (accept) begin
      op_q  <= instr_op;
      rd_q  <= instr_rd;
      imm_q <= instr_imm;
      ra1_q <= instr_rs1;
      ra2_q <= instr_rs2;
    end
  end

  // Stage 1: capture register file read data at the end of READ.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (ld_operands) begin
      a_q <= rd1;
      b_q <= rd2;
    end
  end

  // Stage 2: register the ALU result into the write port for the WB cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wa_q   <= '0;
      wd_q   <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
    end else if (ld_result) begin
      wa_q   <= rd_q;
      wd_q   <= wd_d;
      we_q   <= (op_q != OP_NOP);
      done_q <= 1'b1;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
    end
  end

`ifdef RF_EXEC_FLAGS_EN
  logic flag_z_q, flag_c_q;

  // Flags change together with the write port; NOP leaves them untouched.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if (ld_result && (op_q != OP_NOP)) begin
      flag_z_q <= (wd_d == '0);
      flag_c_q <= alu_carry(op_q, a_q, b_q);
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`endif

  assign ra1  = ra1_q;
  assign ra2  = ra2_q;
  assign wa   = wa_q;
  assign wd   = wd_q;
  assign we   = we_q;
  assign done = done_q;

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// tb_rf_exec_ctrl: bench for rf_exec_ctrl with a behavioural register file
// attached to the read/write ports. Directed scenarios are followed by
// randomized instruction streams. Every result is compared against an
// arithmetic reference model of the instruction set.
module tb_rf_exec_ctrl;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm;
  } instr_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = 3'd7;
  logic [2:0] instr_rd = 3'd0;
  logic [2:0] instr_rs1 = 3'd0;
  logic [2:0] instr_rs2 = 3'd0;
  logic [7:0] instr_imm = 8'd0;
  logic [2:0] ra1, ra2, wa;
  logic [7:0] rd1, rd2, wd;
  logic       we, done;
`ifdef RF_EXEC_FLAGS_EN
  logic       flag_z, flag_c;
`endif

  logic [7:0] rf     [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] ref_rf [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  bit         exp_z = 1'b0;
  bit         exp_c = 1'b0;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int we_cnt   = 0;

  rf_exec_ctrl #(.DW(8), .AW(3)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_imm   (instr_imm),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .wa          (wa),
    .wd          (wd),
    .we          (we),
    .done        (done)
`ifdef RF_EXEC_FLAGS_EN
    ,
    .flag_z      (flag_z),
    .flag_c      (flag_c)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Register file: combinational read, synchronous write.
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
  always @(posedge sys_clk) begin
    if (we) rf[wa] <= wd;
  end

  // Handshake and write-pulse counters.
  always @(posedge sys_clk) begin
    if (instr_valid && instr_ready && !sys_rst) acc_cnt <= acc_cnt + 1;
    if (we) we_cnt <= we_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference semantics straight from the instruction definitions.
  task automatic model(input instr_t in, output logic [7:0] r, output bit w,
                       output bit z, output bit c);
    int a, b, t;
    a = int'(ref_rf[in.rs1]);
    b = int'(ref_rf[in.rs2]);
    t = 0;
    c = 1'b0;
    w = 1'b1;
    case (in.op)
      3'd0: begin t = a + b; c = (t > 255); end
      3'd1: begin t = a - b; c = (a < b); end
      3'd2: t = a & b;
      3'd3: t = a | b;
      3'd4: t = a ^ b;
      3'd5: begin t = a * 2; c = (t > 255); end
      3'd6: t = int'(in.imm);
      default: begin t = 0; w = 1'b0; end
    endcase
    r = 8'(t);
    z = (r == 8'h00);
  endtask

  task automatic drive(input instr_t in);
    instr_op  = in.op;
    instr_rd  = in.rd;
    instr_rs1 = in.rs1;
    instr_rs2 = in.rs2;
    instr_imm = in.imm;
  endtask

  function automatic instr_t mk(input int op, input int rd, input int rs1,
                                input int rs2, input int imm);
    instr_t i;
    i.op  = 3'(op);
    i.rd  = 3'(rd);
    i.rs1 = 3'(rs1);
    i.rs2 = 3'(rs2);
    i.imm = 8'(imm);
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    return mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)));
  endfunction

  // Issue one instruction from IDLE and follow it through to IDLE again.
  // With keep set, valid stays high and the next instruction is presented
  // while the controller is busy.
  task automatic exec_instr(input instr_t in, input bit keep, input instr_t nxt);
    logic [7:0] er;
    bit ew, ez, ec;
    int a0;
    model(in, er, ew, ez, ec);
    check_eq("ready_idle", 32'(instr_ready), 32'd1);
    a0 = acc_cnt;
    drive(in);
    instr_valid = 1'b1;
    @(posedge sys_clk); #1;
    if (keep) drive(nxt);
    else instr_valid = 1'b0;
    check_eq("ready_read", 32'(instr_ready), 32'd0);
    check_eq("ra1_read", 32'(ra1), 32'(in.rs1));
    check_eq("ra2_read", 32'(ra2), 32'(in.rs2));
    check_eq("accept_once", 32'(acc_cnt), 32'(a0 + 1));
    @(posedge sys_clk); #1;
    check_eq("we_exec", 32'(we), 32'd0);
    check_eq("done_exec", 32'(done), 32'd0);
    @(posedge sys_clk); #1;
    check_eq("done_wb", 32'(done), 32'd1);
    check_eq("we_wb", 32'(we), 32'(ew));
    if (ew) begin
      check_eq("wa_wb", 32'(wa), 32'(in.rd));
      check_eq("wd_wb", 32'(wd), 32'(er));
      ref_rf[in.rd] = er;
      exp_z = ez;
      exp_c = ec;
    end
`ifdef RF_EXEC_FLAGS_EN
    check_eq("flag_z", 32'(flag_z), 32'(exp_z));
    check_eq("flag_c", 32'(flag_c), 32'(exp_c));
`endif
    @(posedge sys_clk); #1;
    check_eq("ready_back", 32'(instr_ready), 32'd1);
    check_eq("done_clear", 32'(done), 32'd0);
    check_eq("we_clear", 32'(we), 32'd0);
    check_eq("no_double_accept", 32'(acc_cnt), 32'(a0 + 1));
    check_eq("rf_written", 32'(rf[in.rd]), 32'(ref_rf[in.rd]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(instr_ready), 32'd1);
    check_eq({tag, "_we"}, 32'(we), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_ra1"}, 32'(ra1), 32'd0);
    check_eq({tag, "_ra2"}, 32'(ra2), 32'd0);
    check_eq({tag, "_wa"}, 32'(wa), 32'd0);
    check_eq({tag, "_wd"}, 32'(wd), 32'd0);
`ifdef RF_EXEC_FLAGS_EN
    check_eq({tag, "_flag_z"}, 32'(flag_z), 32'd0);
    check_eq({tag, "_flag_c"}, 32'(flag_c), 32'd0);
`endif
  endtask

  initial begin
    instr_t cur, nxt, nop_i;
    bit keep, have_next;
    int we0, gap;
    nop_i = mk(7, 0, 0, 0, 0);

    // Power-up reset.
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("rst");
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Directed sequence.
    exec_instr(mk(6, 3, 0, 0, 8'h5A), 1'b0, nop_i);
    exec_instr(mk(6, 1, 0, 0, 8'hF0), 1'b0, nop_i);
    exec_instr(mk(6, 2, 0, 0, 8'h20), 1'b0, nop_i);
    exec_instr(mk(0, 4, 1, 2, 0), 1'b0, nop_i);
    exec_instr(mk(1, 1, 2, 1, 0), 1'b0, nop_i);
    exec_instr(mk(3, 5, 1, 1, 0), 1'b0, nop_i);
    exec_instr(nop_i, 1'b1, mk(6, 0, 0, 0, 8'hA5));
    exec_instr(mk(6, 0, 0, 0, 8'hA5), 1'b0, nop_i);

    // Reset during EXEC abandons the instruction.
    we0 = we_cnt;
    drive(mk(0, 6, 1, 2, 0));
    instr_valid = 1'b1;
    @(posedge sys_clk); #1;
    instr_valid = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_z = 1'b0;
    exp_c = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk); #2;
    sys_rst = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    check_eq("midrst_no_we", 32'(we_cnt), 32'(we0));
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_idle", 32'(instr_ready), 32'd1);
    check_eq("midrst_r6", 32'(rf[6]), 32'(ref_rf[6]));

    // Shift with the MSB falling off.
    exec_instr(mk(6, 7, 0, 0, 8'h81), 1'b0, nop_i);
    exec_instr(mk(5, 7, 7, 7, 0), 1'b0, nop_i);

    // Randomized stream with idle gaps and back-to-back presentation.
    have_next = 1'b0;
    nxt = nop_i;
    for (int n = 0; n < 80; n++) begin
      cur = have_next ? nxt : rnd_instr();
      keep = ($urandom_range(0, 3) == 0);
      nxt = rnd_instr();
      exec_instr(cur, keep, nxt);
      have_next = keep;
      if (!keep) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          @(posedge sys_clk); #1;
        end
      end
    end

    // Final register file contents.
    for (int r = 0; r < 8; r++) begin
      check_eq("rf_final", 32'(rf[r]), 32'(ref_rf[r]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_exec_ctrl.md
Name: rf_exec_ctrl

Overview:
- Multi-cycle execute/write-back sequencer that sits directly upstream of the 8x8 register file.
- Accepts one register-to-register instruction through a valid/ready handshake and drives the register file read addresses.
- Captures rd1/rd2 from the register file, computes an 8-bit ALU result and drives the write port (wa/wd/we) for one cycle.
- Pulses done when the instruction retires.

Parameters:
- DW, 8, data width; must match register file word width.
- AW, 3, register address width (2**AW registers).

Ports:
- sys_clk  in  1  system clock, all state updates on rising edge.
- sys_rst  in  1  reset; asynchronous, active-high.
- instr_valid  in  1  instruction present on instr_op/instr_*.
- instr_ready  out  1  controller can accept an instruction.
- instr_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1 (rs1<<1), 110 LDI (write imm), 111 NOP.
- instr_rd  in  AW  destination register.
- instr_rs1  in  AW  source register 1.
- instr_rs2  in  AW  source register 2.
- instr_imm  in  DW  immediate for LDI.
- ra1  out  AW  register file read address 1.
- ra2  out  AW  register file read address 2.
- rd1  in  DW  register file read data 1 (combinational read).
- rd2  in  DW  register file read data 2 (combinational read).
- wa  out  AW  register file write address.
- wd  out  DW  register file write data.
- we  out  1  register file write enable.
- done  out  1  one-cycle pulse at retirement.

Behaviour:
- Reset (async, immediate): state=IDLE; instr_ready=1; ra1=ra2=wa=0; wd=0; we=0; done=0; all internal latches cleared.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. All outputs are registered or decoded from registered state only.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at edge T: latch op/rd/rs1/rs2/imm; go to READ.
  - With no valid, stay in IDLE.
- READ (cycle T+1):
  - instr_ready=0; ra1=latched rs1, ra2=latched rs2.
  - At end of cycle, capture rd1/rd2 into operand registers A/B; go to EXEC.
- EXEC (T+2): compute result R from A/B/imm; go to WB.
  - ADD/SUB: modulo 2**DW, wrap-around, no saturation.
  - SHL1: bit DW-1 discarded, LSB=0.
  - LDI: R=imm; operands ignored.
- WB (T+3):
  - wa=latched rd; wd=R; done=1.
  - we=1 except for NOP (we=0, done still 1).
  - Go to IDLE.
- Timing: accept-to-write latency is 3 cycles. Throughput is 1 instruction per 4 cycles; instr_ready reasserts at T+4.
- Addressing:
  - Any register 0..2**AW-1 is writable, including register 0.
  - rs1==rs2 is legal.
  - rd==rs1 is legal: operands are captured in READ, before the write in WB.
- instr_valid while not ready: ignored. Inputs are held by the upstream until accepted; no internal queue.
- ra1/ra2 hold their last value outside READ; the register file ignores them.
- Reset asserted mid-instruction (any state): instruction abandoned, no write occurs, outputs take reset values immediately.

Optional Feature:
- Macro: RF_EXEC_FLAGS_EN.
- When defined:
  - Adds outputs flag_z (1) and flag_c (1), both registered and reset to 0.
  - Updated only in WB of a writing instruction. NOP holds both flags.
  - flag_z = (R==0).
  - flag_c = carry-out for ADD, borrow (A<B) for SUB, shifted-out bit for SHL1, 0 otherwise.
- When undefined: ports absent; no flag logic.

Test Plan:
- Reset then LDI rd=3 imm=8'h5A -> instr_ready=1 after reset; at T+3 we=1, wa=3, wd=8'h5A, done=1; instr_ready=1 at T+4.
- Preload r1=8'hF0, r2=8'h20 via LDI; ADD rd=4 rs1=1 rs2=2 -> wd=8'h10 (wrap). With flags: flag_c=1, flag_z=0.
- With r1=8'hF0, r2=8'h20: SUB rd=1 rs1=2 rs2=1 (rd==rs2) -> wd=8'h30. Subsequent OR rd=5 rs1=1 rs2=1 -> wd=8'h30. With flags: flag_c=1 on the SUB.
- NOP, with instr_valid held high through BUSY and a second LDI behind it -> NOP gives done=1, we=0. Second instruction accepted exactly 4 cycles after the first; no double-accept.
- Assert sys_rst during EXEC of ADD rd=6 -> we never pulses, done stays 0, state returns to IDLE, r6 unchanged.
- Wrap-around at the register boundary: SHL1 rd=7 rs1=7 with r7=8'h81 -> wd=8'h02. With flags: flag_c=1.
